// File: rtl/frv_dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// frv_dmem_responder_pkg
// Shared definitions for the data-memory responder and its helpers:
//   - dmem bus widths (strobe, data, byte offset)
//   - responder FSM state encoding
//   - captured request record
//   - tap mask for the 16-bit stall LFSR
// No ports; imported with "import frv_dmem_responder_pkg::*;".
// ---------------------------------------------------------------------------
package frv_dmem_responder_pkg;

    localparam int DMEM_STRB_W = 4;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_OFFS_W = 2;

    // Taps 16/14/13/11 of x^16 + x^14 + x^13 + x^11 + 1, as bit positions 15/13/12/10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    // Request fields as captured while the initiator is being stalled.
    typedef struct packed {
        logic [31:0]            addr;
        logic                   wen;
        logic [DMEM_STRB_W-1:0] strb;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/frv_lfsr16.sv
// ---------------------------------------------------------------------------
// frv_lfsr16
// 16-bit Fibonacci LFSR (taps 16/14/13/11). Shifts left, feedback enters bit 0.
// Ports:
//   clk     in   clock
//   resetn  in   asynchronous active-low reset, loads seed
//   seed    in   16-bit reset value, must be non-zero
//   enable  in   advance one step on this clock edge
//   q       out  current LFSR state
// ---------------------------------------------------------------------------
module frv_lfsr16
    import frv_dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] seed,
    input  logic        enable,
    output logic [15:0] q
);

    // Shift register state; a zero seed would lock the sequence at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= seed;
        end else if (enable) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/frv_dmem_responder.sv
// ---------------------------------------------------------------------------
// frv_dmem_responder
// Target-side data RAM behind the LSU dmem_* interface. Word-organised storage
// with a fixed wait-state count, optional LFSR-driven extra stalls, range-checked
// error responses and a sticky protocol-violation flag.
// Ports:
//   g_clk       in   clock
//   g_resetn    in   asynchronous active-low reset
//   dmem_cen    in   request valid
//   dmem_wen    in   1 = write, 0 = read
//   dmem_strb   in   byte-lane write strobe
//   dmem_addr   in   byte address, bits [1:0] ignored for addressing
//   dmem_wdata  in   write data
//   dmem_stall  out  request not accepted this cycle
//   dmem_error  out  bus error, valid in the acceptance cycle
//   dmem_rdata  out  read data, valid in the acceptance cycle
//   prot_err    out  sticky: request changed while stalled
// ---------------------------------------------------------------------------
module frv_dmem_responder
    import frv_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter int          RAND_STALL  = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   dmem_cen,
    input  logic                   dmem_wen,
    input  logic [DMEM_STRB_W-1:0] dmem_strb,
    input  logic [31:0]            dmem_addr,
    input  logic [DMEM_DATA_W-1:0] dmem_wdata,
    output logic                   dmem_stall,
    output logic                   dmem_error,
    output logic [DMEM_DATA_W-1:0] dmem_rdata,
    output logic                   prot_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) << 2;
    localparam bit          DIRECT   = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the compare.
    function automatic logic addr_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+DMEM_OFFS_W-1:DMEM_OFFS_W];
    endfunction

    logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

    resp_state_e            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    dmem_req_t              req_q, req_d;
    logic [DMEM_DATA_W-1:0] rdata_q, rdata_d;
    logic                   prot_q, prot_d;

    dmem_req_t              live_req;
    logic                   live_ok, req_ok;
    logic [IDX_W-1:0]       live_idx, req_idx;

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [DMEM_DATA_W-1:0] wr_data;
    logic [DMEM_STRB_W-1:0] wr_strb;

    logic [15:0]            lfsr;
    logic                   rand_hit;
    logic                   unused_lfsr_hi;

    assign live_req = '{addr: dmem_addr, wen: dmem_wen, strb: dmem_strb, wdata: dmem_wdata};
    assign live_ok  = addr_in_range(dmem_addr);
    assign live_idx = word_index(dmem_addr);
    assign req_ok   = addr_in_range(req_q.addr);
    assign req_idx  = word_index(req_q.addr);

    frv_lfsr16 u_lfsr (
        .clk    (g_clk),
        .resetn (g_resetn),
        .seed   (LFSR_SEED),
        .enable (RAND_STALL != 0),
        .q      (lfsr)
    );

    // Only bit 0 decides a stall; the rest of the state just carries the sequence.
    assign rand_hit       = (RAND_STALL != 0) && lfsr[0];
    assign unused_lfsr_hi = ^lfsr[15:1];

    // Next-state and bus outputs. A direct IDLE accept (zero wait states) reads the
    // array combinationally, so it returns the word as it was before any write this cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        prot_d     = prot_q;
        dmem_stall = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = '0;
        wr_en      = 1'b0;
        wr_idx     = live_idx;
        wr_data    = dmem_wdata;
        wr_strb    = dmem_strb;

        case (state_q)
            ST_IDLE: begin
                if (dmem_cen) begin
                    if (DIRECT && !rand_hit) begin
                        dmem_error = !live_ok;
                        dmem_rdata = (live_ok && !dmem_wen) ? mem[live_idx] : '0;
                        wr_en      = dmem_wen && live_ok;
                    end else begin
                        dmem_stall = 1'b1;
                        req_d      = live_req;
                        cnt_d      = CNT_LOAD;
                        state_d    = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                dmem_stall = 1'b1;
                if (!dmem_cen) begin
                    // Initiator withdrew the request: drop it without writing.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    if (live_req != req_q) begin
                        prot_d = 1'b1;
                    end
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!rand_hit) begin
                        state_d = ST_RESP;
                        rdata_d = (req_ok && !req_q.wen) ? mem[req_idx] : '0;
                    end
                end
            end

            ST_RESP: begin
                dmem_error = !req_ok;
                dmem_rdata = rdata_q;
                wr_en      = dmem_cen && req_q.wen && req_ok;
                wr_idx     = req_idx;
                wr_data    = req_q.wdata;
                wr_strb    = req_q.strb;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and response registers; the array itself has no reset.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            prot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            prot_q  <= prot_d;
        end
    end

    // Byte-lane write at the end of the acceptance cycle; gated so nothing commits in reset.
    always_ff @(posedge g_clk) begin
        if (wr_en && g_resetn) begin
            for (int b = 0; b < DMEM_STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign prot_err = prot_q;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_frv_dmem_responder
// Self-checking bench for frv_dmem_responder. Three instances share the request
// fields: u_main (2 wait states), u_zero (0 wait states) and u_rand (0 wait
// states with LFSR stalls). Each instance has its own dmem_cen.
// ---------------------------------------------------------------------------
module tb_frv_dmem_responder;

    logic        g_clk;
    logic        g_resetn;
    logic        dmem_wen;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;

    logic        m_cen, m_stall, m_error, m_prot;
    logic [31:0] m_rdata;
    logic        z_cen, z_stall, z_error, z_prot;
    logic [31:0] z_rdata;
    logic        r_cen, r_stall, r_error, r_prot;
    logic [31:0] r_rdata;

    int total;
    int bad;

    logic [15:0] lfsr_m;

    frv_dmem_responder #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0002_0000), .WAIT_CYCLES(2),
        .RAND_STALL(0), .LFSR_SEED(16'hACE1)
    ) u_main (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem_cen(m_cen), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_stall(m_stall), .dmem_error(m_error), .dmem_rdata(m_rdata), .prot_err(m_prot)
    );

    frv_dmem_responder #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0002_0000), .WAIT_CYCLES(0),
        .RAND_STALL(0), .LFSR_SEED(16'hACE1)
    ) u_zero (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem_cen(z_cen), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_stall(z_stall), .dmem_error(z_error), .dmem_rdata(z_rdata), .prot_err(z_prot)
    );

    frv_dmem_responder #(
        .DEPTH_WORDS(1024), .BASE_ADDR(32'h0002_0000), .WAIT_CYCLES(0),
        .RAND_STALL(1), .LFSR_SEED(16'hACE1)
    ) u_rand (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem_cen(r_cen), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_stall(r_stall), .dmem_error(r_error), .dmem_rdata(r_rdata), .prot_err(r_prot)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, new bit shifted in at the bottom every cycle.
    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) lfsr_m <= 16'hACE1;
        else           lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    typedef struct {
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stalls;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic applyStimulus(input logic wen, input logic [3:0] strb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        dmem_wen   = wen;
        dmem_strb  = strb;
        dmem_addr  = addr;
        dmem_wdata = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge g_clk);
        #1;
    endtask

    // One request on u_main, held until accepted or a 20-cycle budget runs out.
    task automatic mainXfer(input logic wen, input logic [3:0] strb, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls, output logic err,
                            output logic [31:0] rd, output logic done);
        applyStimulus(wen, strb, addr, wdata);
        m_cen  = 1'b1;
        stalls = 0;
        done   = 1'b0;
        err    = 1'b0;
        rd     = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge g_clk);
            if (!m_stall) begin
                err  = m_error;
                rd   = m_rdata;
                done = 1'b1;
            end else begin
                stalls++;
            end
            nextCycle();
            if (done) break;
        end
        m_cen = 1'b0;
    endtask

    // Four writes then four reads with cen held high throughout. Expected stall
    // per cycle comes from a spec-level model (IDLE/WAIT/RESP) driven by lfsr_m.
    task automatic runStream(input bit use_rand, input string tag);
        int          k;
        int          mst;
        logic        exp_stall, act_stall, act_err;
        logic [31:0] act_rd, exp_rd;
        k   = 0;
        mst = 0;
        applyStimulus(1'b1, 4'hF, 32'h0002_0100, 32'hA500_0000);
        if (use_rand) r_cen = 1'b1; else z_cen = 1'b1;
        for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
            @(negedge g_clk);
            if (!use_rand)     exp_stall = 1'b0;
            else if (mst == 0) exp_stall = lfsr_m[0];
            else               exp_stall = (mst == 1);
            act_stall = use_rand ? r_stall : z_stall;
            act_err   = use_rand ? r_error : z_error;
            act_rd    = use_rand ? r_rdata : z_rdata;
            checkOutput($sformatf("%s_stall_k%0d", tag, k), {31'd0, act_stall}, {31'd0, exp_stall});
            if (!exp_stall) begin
                exp_rd = (k < 4) ? 32'h0 : (32'hA500_0000 | 32'(k - 4));
                checkOutput($sformatf("%s_err_k%0d", tag, k), {31'd0, act_err}, 32'd0);
                checkOutput($sformatf("%s_rdata_k%0d", tag, k), act_rd, exp_rd);
            end
            if (use_rand) begin
                if (mst == 0)      mst = lfsr_m[0] ? 1 : 0;
                else if (mst == 1) mst = lfsr_m[0] ? 1 : 2;
                else               mst = 0;
            end
            nextCycle();
            if (!exp_stall) begin
                k++;
                if (k < 4)
                    applyStimulus(1'b1, 4'hF, 32'h0002_0100 + 32'(4 * k), 32'hA500_0000 | 32'(k));
                else if (k < 8)
                    applyStimulus(1'b0, 4'hF, 32'h0002_0100 + 32'(4 * (k - 4)), 32'h0);
            end
        end
        r_cen = 1'b0;
        z_cen = 1'b0;
        checkOutput({tag, "_complete"}, 32'(k), 32'd8);
    endtask

    initial begin
        int          st;
        logic        er, dn;
        logic [31:0] rd;

        total    = 0;
        bad      = 0;
        g_resetn = 1'b0;
        m_cen    = 1'b0;
        z_cen    = 1'b0;
        r_cen    = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);

        vecs[0]  = '{1'b1, 4'hF, 32'h0002_0010, 32'hDEAD_BEEF, 3, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'h0002_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 4'hF, 32'h0002_0020, 32'hAABB_CCDD, 3, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h5, 32'h0002_0020, 32'h1122_3344, 3, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'hF, 32'h0002_0020, 32'h0,         3, 1'b0, 32'hAA22_CC44};
        vecs[5]  = '{1'b0, 4'hF, 32'h0002_1000, 32'h0,         3, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 4'hF, 32'h0001_FFFC, 32'h0,         3, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 4'hF, 32'h0002_0FFC, 32'hCAFE_F00D, 3, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'hF, 32'h0002_1000, 32'h1234_5678, 3, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'h0001_FFFC, 32'h8765_4321, 3, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 32'h0002_0010, 32'h0,         3, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'hF, 32'h0002_0FFC, 32'h0,         3, 1'b0, 32'hCAFE_F00D};
        vecs[12] = '{1'b0, 4'h0, 32'h0002_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF};

        repeat (3) nextCycle();
        checkOutput("reset_stall", {31'd0, m_stall}, 32'd0);
        checkOutput("reset_error", {31'd0, m_error}, 32'd0);
        checkOutput("reset_rdata", m_rdata, 32'd0);
        checkOutput("reset_prot",  {31'd0, m_prot},  32'd0);
        g_resetn = 1'b1;
        nextCycle();

        $display("[TB] table vectors on 2-wait-state instance");
        for (int i = 0; i < 13; i++) begin
            mainXfer(vecs[i].wen, vecs[i].strb, vecs[i].addr, vecs[i].wdata, st, er, rd, dn);
            checkOutput($sformatf("vec%0d_done", i),   {31'd0, dn}, 32'd1);
            checkOutput($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].stalls));
            checkOutput($sformatf("vec%0d_error", i),  {31'd0, er}, {31'd0, vecs[i].err});
            checkOutput($sformatf("vec%0d_rdata", i),  rd, vecs[i].rdata);
        end

        $display("[TB] address changed while stalled");
        checkOutput("prot_before", {31'd0, m_prot}, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0002_0010, 32'h0);
        m_cen = 1'b1;
        nextCycle();
        dmem_addr = 32'h0002_0014;
        @(negedge g_clk);
        checkOutput("prot_wait_stall", {31'd0, m_stall}, 32'd1);
        nextCycle();
        checkOutput("prot_set", {31'd0, m_prot}, 32'd1);
        nextCycle();
        @(negedge g_clk);
        checkOutput("prot_resp_stall", {31'd0, m_stall}, 32'd0);
        checkOutput("prot_resp_rdata", m_rdata, 32'hDEAD_BEEF);
        nextCycle();
        m_cen = 1'b0;
        repeat (2) nextCycle();
        checkOutput("prot_held", {31'd0, m_prot}, 32'd1);

        $display("[TB] write withdrawn mid-wait");
        applyStimulus(1'b1, 4'hF, 32'h0002_0010, 32'h5555_5555);
        m_cen = 1'b1;
        nextCycle();
        m_cen = 1'b0;
        @(negedge g_clk);
        checkOutput("abort_wait_stall", {31'd0, m_stall}, 32'd1);
        nextCycle();
        @(negedge g_clk);
        checkOutput("abort_idle_stall", {31'd0, m_stall}, 32'd0);
        nextCycle();
        mainXfer(1'b0, 4'hF, 32'h0002_0010, 32'h0, st, er, rd, dn);
        checkOutput("abort_read_stalls", 32'(st), 32'd3);
        checkOutput("abort_read_rdata", rd, 32'hDEAD_BEEF);

        $display("[TB] zero-wait back-to-back stream");
        runStream(1'b0, "zero");
        $display("[TB] zero-wait stream with random stalls");
        runStream(1'b1, "rand");

        $display("[TB] reset during a stalled write");
        applyStimulus(1'b1, 4'hF, 32'h0002_0010, 32'h7777_7777);
        m_cen = 1'b1;
        nextCycle();
        #2;
        g_resetn = 1'b0;
        m_cen    = 1'b0;
        #1;
        checkOutput("rst_mid_stall", {31'd0, m_stall}, 32'd0);
        checkOutput("rst_mid_error", {31'd0, m_error}, 32'd0);
        checkOutput("rst_mid_rdata", m_rdata, 32'd0);
        checkOutput("rst_mid_prot",  {31'd0, m_prot},  32'd0);
        nextCycle();
        g_resetn = 1'b1;
        nextCycle();
        mainXfer(1'b0, 4'hF, 32'h0002_0010, 32'h0, st, er, rd, dn);
        checkOutput("rst_read_stalls", 32'(st), 32'd3);
        checkOutput("rst_read_rdata", rd, 32'hDEAD_BEEF);
        checkOutput("rst_read_error", {31'd0, er}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
